// File: rtl/pwm_duty_sched_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and constants for the PWM duty scheduler.
//   sched_state_t : scheduler state encoding
//   DUTY_ZERO     : 11-bit duty code that produces zero torque at the H-bridge
// -----------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, RAMP_DN, FAULT} sched_state_t;

    localparam logic [10:0] DUTY_ZERO = 11'h400;

endpackage

// File: rtl/pwm_duty_sched_if.sv
// -----------------------------------------------------------------------------
// pwm_duty_sched_if
// Bundle between the scheduler and its surroundings.
//   en, duty_req           : drive request and signed torque request
//   PWM_synch, ovr_I_blank : period boundary pulse and blanking window (PWM11)
//   OVR_I, clr_fault       : over-current comparator and fault clear pulse
//   duty, fault, running   : registered scheduler outputs
// master drives requests and observes outputs; slave is the scheduler.
// -----------------------------------------------------------------------------
interface pwm_duty_sched_if;

    logic               en;
    logic signed [11:0] duty_req;
    logic               PWM_synch;
    logic               ovr_I_blank;
    logic               OVR_I;
    logic               clr_fault;
    logic [10:0]        duty;
    logic               fault;
    logic               running;

    modport master (
        output en, duty_req, PWM_synch, ovr_I_blank, OVR_I, clr_fault,
        input  duty, fault, running
    );

    modport slave (
        input  en, duty_req, PWM_synch, ovr_I_blank, OVR_I, clr_fault,
        output duty, fault, running
    );

endinterface

// File: rtl/pwm_duty_sched_duty_slew.sv
// -----------------------------------------------------------------------------
// duty_slew
// Combinational clamp + slew step.
//   i_duty_req  : signed torque request
//   i_sel_zero  : 1 -> effective target is DUTY_ZERO, 0 -> clamped request
//   i_duty      : current registered duty
//   o_next_duty : duty after one slew-limited step toward the effective target
// -----------------------------------------------------------------------------
module duty_slew
    import pwm_pkg::*;
#(
    parameter logic [10:0] SLEW_STEP = 11'd32,
    parameter logic [10:0] MAX_MAG   = 11'd960
) (
    input  logic signed [11:0] i_duty_req,
    input  logic               i_sel_zero,
    input  logic        [10:0] i_duty,
    output logic        [10:0] o_next_duty
);

    logic signed [11:0] w_mag_pos;
    logic signed [11:0] w_mag_neg;
    logic signed [11:0] w_step_pos;
    logic signed [11:0] w_step_neg;
    logic signed [11:0] w_clamped;
    logic signed [11:0] w_tgt;
    logic signed [11:0] w_tgt_eff;
    logic signed [11:0] w_duty_s;
    logic signed [11:0] w_diff;
    logic signed [11:0] w_next;
    logic               w_unused_msb;

    assign w_mag_pos  = signed'({1'b0, MAX_MAG});
    assign w_mag_neg  = -w_mag_pos;
    assign w_step_pos = signed'({1'b0, SLEW_STEP});
    assign w_step_neg = -w_step_pos;

    // -2048 compares below -MAX_MAG, so it clamps like any other large negative.
    always_comb begin
        w_clamped = i_duty_req;
        if (i_duty_req > w_mag_pos) begin
            w_clamped = w_mag_pos;
        end else if (i_duty_req < w_mag_neg) begin
            w_clamped = w_mag_neg;
        end
    end

    assign w_tgt     = signed'({1'b0, DUTY_ZERO}) + w_clamped;
    assign w_tgt_eff = i_sel_zero ? signed'({1'b0, DUTY_ZERO}) : w_tgt;
    assign w_duty_s  = signed'({1'b0, i_duty});
    // Both operands lie in [0, 2047], so the 12-bit signed difference cannot wrap.
    assign w_diff    = w_tgt_eff - w_duty_s;

    always_comb begin
        w_next = w_tgt_eff;
        if (w_diff > w_step_pos) begin
            w_next = w_duty_s + w_step_pos;
        end else if (w_diff < w_step_neg) begin
            w_next = w_duty_s - w_step_pos;
        end
    end

    // The step result is always inside the legal duty range, so bit 11 is zero.
    assign o_next_duty  = w_next[10:0];
    assign w_unused_msb = w_next[11];

endmodule

// File: rtl/pwm_duty_sched.sv
// -----------------------------------------------------------------------------
// pwm_duty_sched
// Per-channel duty scheduler in front of one PWM11 H-bridge. Converts a signed
// torque request to an 11-bit duty (0x400 = zero torque), steps duty only at
// PWM period boundaries with slew limiting, sequences enable/disable ramps and
// latches an over-current fault.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : pwm_duty_sched_if.slave (requests in, duty/fault/running out)
// -----------------------------------------------------------------------------
module pwm_duty_sched
    import pwm_pkg::*;
#(
    parameter logic [10:0] SLEW_STEP = 11'd32,
    parameter logic [10:0] MAX_MAG   = 11'd960,
    parameter logic [3:0]  OVR_LIMIT = 4'd8
) (
    input  logic               clk,
    input  logic               rst,
    pwm_duty_sched_if.slave    bus
);

    sched_state_t r_state;
    logic [10:0]  r_duty;
    logic         r_fault;
    logic         r_running;
    logic [3:0]   r_ovr_cnt;
    logic         r_ovr_seen;

    logic         w_active;
    logic         w_ovr_evt;
    logic         w_ovr_hit;
    logic [3:0]   w_cnt_inc;
    logic [3:0]   w_cnt_next;
    logic         w_trip;
    logic [10:0]  w_next_duty;

    assign w_active   = (r_state == RUN) || (r_state == RAMP_DN);
    assign w_ovr_evt  = bus.OVR_I && !bus.ovr_I_blank && w_active;
    // An event coincident with PWM_synch belongs to the period that is ending.
    assign w_ovr_hit  = r_ovr_seen || w_ovr_evt;
    assign w_cnt_inc  = (r_ovr_cnt >= OVR_LIMIT) ? OVR_LIMIT : r_ovr_cnt + 4'd1;
    assign w_cnt_next = w_ovr_hit ? w_cnt_inc : 4'd0;
    assign w_trip     = w_active && w_ovr_hit && (w_cnt_inc == OVR_LIMIT);

    // The en level at the boundary picks the target, so the IDLE->RUN boundary
    // already steps toward the request and RUN->RAMP_DN already steps to zero.
    duty_slew #(
        .SLEW_STEP (SLEW_STEP),
        .MAX_MAG   (MAX_MAG)
    ) u_duty_slew (
        .i_duty_req  (bus.duty_req),
        .i_sel_zero  (!bus.en),
        .i_duty      (r_duty),
        .o_next_duty (w_next_duty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_duty     <= DUTY_ZERO;
            r_fault    <= 1'b0;
            r_running  <= 1'b0;
            r_ovr_cnt  <= 4'd0;
            r_ovr_seen <= 1'b0;
        end else begin
            if (bus.PWM_synch) begin
                r_ovr_seen <= 1'b0;
                r_ovr_cnt  <= w_cnt_next;
            end else if (w_ovr_evt) begin
                r_ovr_seen <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.PWM_synch) begin
                        r_duty <= w_next_duty;
                        if (bus.en) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                end
                RUN, RAMP_DN: begin
                    if (bus.PWM_synch) begin
                        if (w_trip) begin
                            r_state   <= FAULT;
                            r_duty    <= DUTY_ZERO;
                            r_fault   <= 1'b1;
                            r_running <= 1'b0;
                        end else begin
                            r_duty <= w_next_duty;
                            if (bus.en) begin
                                r_state   <= RUN;
                                r_running <= 1'b1;
                            end else if (r_state == RUN || w_next_duty != DUTY_ZERO) begin
                                r_state   <= RAMP_DN;
                                r_running <= 1'b0;
                            end else begin
                                r_state   <= IDLE;
                                r_running <= 1'b0;
                            end
                        end
                    end
                end
                FAULT: begin
                    r_duty <= DUTY_ZERO;
                    if (bus.clr_fault) begin
                        r_state   <= IDLE;
                        r_fault   <= 1'b0;
                        r_ovr_cnt <= 4'd0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.duty    = r_duty;
    assign bus.fault   = r_fault;
    assign bus.running = r_running;

endmodule

// File: tb/tb_pwm_duty_sched.sv
module tb_pwm_duty_sched;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_RAMP  = 2;
    localparam int M_FAULT = 3;

    typedef struct {
        int duty;
        int fault;
        int running;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_duty_sched_if bus ();

    pwm_duty_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_st   = M_IDLE;
    int   m_duty = 1024;
    int   m_cnt  = 0;
    bit   m_seen = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int clamp_req(input int r);
        if (r > 960) return 960;
        if (r < -960) return -960;
        return r;
    endfunction

    // Reference behaviour for one clock edge, evaluated on the inputs about to be sampled.
    task automatic model_clock();
        int  req;
        int  tgt;
        int  d;
        bit  evt;
        bit  hit;
        req = int'(bus.duty_req);
        if (rst) begin
            m_st = M_IDLE; m_duty = 1024; m_cnt = 0; m_seen = 1'b0;
            return;
        end
        evt = bus.OVR_I && !bus.ovr_I_blank && (m_st == M_RUN || m_st == M_RAMP);
        if (m_st == M_FAULT) begin
            if (bus.PWM_synch) begin
                m_cnt  = (m_seen || evt) ? ((m_cnt + 1 > 8) ? 8 : m_cnt + 1) : 0;
                m_seen = 1'b0;
            end
            if (bus.clr_fault) begin
                m_st  = M_IDLE;
                m_cnt = 0;
            end
            return;
        end
        if (!bus.PWM_synch) begin
            if (evt) m_seen = 1'b1;
            return;
        end
        hit    = m_seen || evt;
        m_cnt  = hit ? ((m_cnt + 1 > 8) ? 8 : m_cnt + 1) : 0;
        m_seen = 1'b0;
        if ((m_st == M_RUN || m_st == M_RAMP) && hit && m_cnt == 8) begin
            m_st   = M_FAULT;
            m_duty = 1024;
            return;
        end
        tgt = bus.en ? 1024 + clamp_req(req) : 1024;
        d   = tgt - m_duty;
        if (d > 32)       m_duty = m_duty + 32;
        else if (d < -32) m_duty = m_duty - 32;
        else              m_duty = tgt;
        case (m_st)
            M_IDLE: if (bus.en) m_st = M_RUN;
            M_RUN:  if (!bus.en) m_st = M_RAMP;
            default: begin
                if (bus.en)             m_st = M_RUN;
                else if (m_duty == 1024) m_st = M_IDLE;
            end
        endcase
    endtask

    // One clock: push the expected outputs, let the edge happen, compare.
    task automatic tick();
        exp_t e;
        model_clock();
        e.duty    = m_duty;
        e.fault   = (m_st == M_FAULT) ? 1 : 0;
        e.running = (m_st == M_RUN) ? 1 : 0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("sb_duty", int'(bus.duty), e.duty);
            check("sb_fault", int'(bus.fault), e.fault);
            check("sb_running", int'(bus.running), e.running);
        end
        bus.PWM_synch = 1'b0;
        bus.clr_fault = 1'b0;
    endtask

    // mode 0: clean, 1: blanked pulse, 2: unblanked pulse mid-period,
    // 3: unblanked pulse coincident with PWM_synch
    task automatic period(input int mode);
        for (int c = 0; c < 4; c++) begin
            bus.OVR_I       = 1'b0;
            bus.ovr_I_blank = (c == 1);
            if (c == 1 && (mode == 1 || mode == 2)) begin
                bus.OVR_I       = 1'b1;
                bus.ovr_I_blank = (mode == 1);
            end
            if (c == 3) begin
                bus.PWM_synch = 1'b1;
                if (mode == 3) bus.OVR_I = 1'b1;
            end
            tick();
        end
        bus.OVR_I       = 1'b0;
        bus.ovr_I_blank = 1'b0;
    endtask

    task automatic periods(input int n, input int mode);
        for (int i = 0; i < n; i++) period(mode);
    endtask

    initial begin
        int ramp_exp[4];
        int dn_exp[4];
        rst             = 1'b1;
        bus.en          = 1'b1;
        bus.duty_req    = 12'sd500;
        bus.PWM_synch   = 1'b0;
        bus.ovr_I_blank = 1'b0;
        bus.OVR_I       = 1'b0;
        bus.clr_fault   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_duty", int'(bus.duty), 'h400);
            check("rst_fault", int'(bus.fault), 0);
            check("rst_running", int'(bus.running), 0);
        end
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_hold", int'(bus.duty), 'h400);

        bus.duty_req = 12'sd100;
        ramp_exp = '{'h420, 'h440, 'h460, 'h464};
        for (int i = 0; i < 4; i++) begin
            period(0);
            check("ramp_up", int'(bus.duty), ramp_exp[i]);
            check("ramp_up_run", int'(bus.running), 1);
        end

        bus.en = 1'b0;
        dn_exp = '{'h444, 'h424, 'h404, 'h400};
        for (int i = 0; i < 4; i++) begin
            period(0);
            check("ramp_dn", int'(bus.duty), dn_exp[i]);
            check("ramp_dn_run", int'(bus.running), 0);
        end
        period(0);
        check("idle_hold", int'(bus.duty), 'h400);

        bus.en = 1'b1;
        periods(4, 0);
        check("reup", int'(bus.duty), 'h464);
        bus.en = 1'b0;
        period(0);
        check("dn_one", int'(bus.duty), 'h444);
        bus.en       = 1'b1;
        bus.duty_req = -12'sd100;
        period(0);
        check("resume_duty", int'(bus.duty), 'h424);
        check("resume_run", int'(bus.running), 1);
        periods(5, 0);
        check("neg_settle", int'(bus.duty), 'h39C);

        bus.duty_req = 12'sd0;
        periods(4, 0);
        check("zero_settle", int'(bus.duty), 'h400);
        bus.duty_req = -12'sd2048;
        period(0);
        check("min_first", int'(bus.duty), 'h3E0);
        periods(29, 0);
        check("min_clamp", int'(bus.duty), 'h040);
        period(0);
        check("min_hold", int'(bus.duty), 'h040);

        bus.duty_req = 12'sd0;
        periods(30, 0);
        bus.duty_req = 12'sd100;
        periods(4, 0);
        check("pre_ovr", int'(bus.duty), 'h464);

        bus.clr_fault = 1'b1;
        tick();
        check("clr_ignored", int'(bus.running), 1);

        periods(20, 1);
        check("blank_nofault", int'(bus.fault), 0);
        periods(7, 2);
        period(0);
        periods(7, 2);
        check("gap_nofault", int'(bus.fault), 0);
        check("gap_run", int'(bus.running), 1);
        period(0);
        periods(7, 2);
        check("seven_nofault", int'(bus.fault), 0);
        period(3);
        check("trip_fault", int'(bus.fault), 1);
        check("trip_duty", int'(bus.duty), 'h400);
        check("trip_run", int'(bus.running), 0);

        bus.en = 1'b0;
        period(0);
        bus.en       = 1'b1;
        bus.duty_req = 12'sd700;
        period(2);
        bus.en = 1'b0;
        period(0);
        bus.en = 1'b1;
        period(0);
        check("fault_duty", int'(bus.duty), 'h400);
        check("fault_hold", int'(bus.fault), 1);

        bus.clr_fault = 1'b1;
        tick();
        check("clr_fault", int'(bus.fault), 0);
        check("clr_run", int'(bus.running), 0);
        bus.duty_req = 12'sd100;
        period(0);
        check("after_clr", int'(bus.duty), 'h420);
        check("after_clr_run", int'(bus.running), 1);

        periods(2, 0);
        bus.en = 1'b0;
        period(0);
        check("mid_ramp", int'(bus.duty), 'h440);
        rst = 1'b1;
        tick();
        check("rst_mid_duty", int'(bus.duty), 'h400);
        check("rst_mid_run", int'(bus.running), 0);
        rst = 1'b0;
        period(0);
        check("rst_mid_idle", int'(bus.duty), 'h400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
